// File: rtl/stepper_motion_sequencer.sv
// Command-level sequencer for one stepper axis: buffers move/home commands,
// runs limit-switch homing, mirrors axis position from step/dir feedback and
// reports done/fault status to the host.
module stepper_motion_sequencer #(
  parameter int FIFO_DEPTH      = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOME_TIMEOUT    = 500000000,
  parameter int SETTLE_CYCLES   = 1000,
  parameter int MAX_SPEED       = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [32:0] cmd_data,
  input  logic        limit_sw,
  input  logic        step_in,
  input  logic        dir_in,
  output logic [31:0] stp_control,
  output logic        stp_homing_enable,
  output logic        stp_reset,
  output logic [23:0] position,
  output logic        homed,
  output logic        busy,
  output logic        move_done,
  output logic        fault,
  output logic [1:0]  fault_code,
  input  logic        fault_clear
);

  localparam int          AW            = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] L_FULL        = (AW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] L_DEB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] L_TO_LAST     = 32'(HOME_TIMEOUT - 1);
  localparam logic [31:0] L_SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  L_MAX_SPEED   = 8'(MAX_SPEED);

  typedef enum logic [2:0] {
    S_IDLE, S_HOME_SEEK, S_HOME_RESET, S_MOVE, S_SETTLE, S_FAULT
  } state_t;

  state_t        r_state, w_state_next;
  logic          r_lim_s1, r_lim_s2, r_lim_f;
  logic [31:0]   r_deb_cnt;
  logic          r_step_q, r_step_prev, r_dir_q;
  logic [23:0]   r_position;
  logic [32:0]   r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_timer;
  logic [31:0]   r_ctrl;
  logic          r_homed;
  logic [1:0]    r_fault_code;

  logic [32:0]   w_head;
  logic          w_push, w_pop, w_flush, w_load, w_step_rise;
  logic [1:0]    w_code_next;

  assign w_head      = r_fifo_mem[r_rd_ptr];
  assign cmd_ready   = (r_count != L_FULL) && (r_state != S_FAULT);
  assign w_push      = cmd_valid && cmd_ready;
  assign w_flush     = (w_state_next == S_FAULT) && (r_state != S_FAULT);
  assign w_step_rise = r_step_q && !r_step_prev;
  assign busy        = (r_state != S_IDLE) || (r_count != '0);
  assign stp_control = r_ctrl;
  assign position    = r_position;
  assign homed       = r_homed;
  assign fault_code  = r_fault_code;

  // Limit switch: two-flop synchroniser followed by a stability counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lim_s1  <= 1'b0;
      r_lim_s2  <= 1'b0;
      r_lim_f   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_lim_s1 <= limit_sw;
      r_lim_s2 <= r_lim_s1;
      if (r_lim_s2 == r_lim_f) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == L_DEB_LAST) begin
        r_lim_f   <= r_lim_s2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 32'd1;
      end
    end
  end

  // Position mirror: count registered step rising edges, direction from dir.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_q    <= 1'b0;
      r_step_prev <= 1'b0;
      r_dir_q     <= 1'b0;
      r_position  <= '0;
    end else begin
      r_step_q    <= step_in;
      r_step_prev <= r_step_q;
      r_dir_q     <= dir_in;
      if (r_state == S_HOME_RESET)
        r_position <= '0;
      else if (w_step_rise && !stp_homing_enable)
        r_position <= r_dir_q ? r_position - 24'd1 : r_position + 24'd1;
    end
  end

  // Command FIFO storage; no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo_mem[r_wr_ptr] <= cmd_data;
  end

  // FIFO pointers and occupancy; entering FAULT discards everything queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state, dispatch decisions and state-decoded outputs.
  always_comb begin
    w_state_next      = r_state;
    w_code_next       = r_fault_code;
    w_pop             = 1'b0;
    w_load            = 1'b0;
    stp_homing_enable = 1'b0;
    stp_reset         = 1'b0;
    fault             = 1'b0;
    move_done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_head[32]) begin
            w_state_next = S_HOME_SEEK;
          end else if (w_head[31:24] > L_MAX_SPEED) begin
            w_state_next = S_FAULT;
            w_code_next  = 2'd2;
          end else if (!r_homed) begin
            w_state_next = S_FAULT;
            w_code_next  = 2'd1;
          end else begin
            w_load       = 1'b1;
            w_state_next = (w_head[23:0] == r_position) ? S_SETTLE : S_MOVE;
          end
        end
      end
      S_HOME_SEEK: begin
        stp_homing_enable = 1'b1;
        if (r_timer >= L_TO_LAST) begin
          w_state_next = S_FAULT;
          w_code_next  = 2'd3;
        end else if (r_lim_f) begin
          w_state_next = S_HOME_RESET;
        end
      end
      S_HOME_RESET: begin
        stp_reset = 1'b1;
        if (r_timer == 32'd1) begin
          move_done    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_MOVE: begin
        if (r_lim_f && dir_in) begin
          w_state_next = S_FAULT;
          w_code_next  = 2'd3;
        end else if (r_position == r_ctrl[23:0]) begin
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_timer == L_SETTLE_LAST) begin
          move_done    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_FAULT: begin
        fault = 1'b1;
        if (fault_clear) begin
          w_state_next = S_IDLE;
          w_code_next  = 2'd0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Per-state cycle counter, restarted on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_timer <= '0;
    else if (w_state_next != r_state) r_timer <= '0;
    else                              r_timer <= r_timer + 32'd1;
  end

  // Stepper control word; in FAULT the goal follows position to hold the axis.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_ctrl <= '0;
    else if (r_state == S_HOME_RESET) r_ctrl <= '0;
    else if (r_state == S_FAULT)    r_ctrl[23:0] <= r_position;
    else if (w_load)                r_ctrl <= w_head[31:0];
  end

  // Homed flag and latched fault code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_homed      <= 1'b0;
      r_fault_code <= 2'd0;
    end else begin
      r_fault_code <= w_code_next;
      if (r_state == S_FAULT)
        r_homed <= 1'b0;
      else if (r_state == S_HOME_RESET && r_timer == 32'd1)
        r_homed <= 1'b1;
    end
  end

endmodule
